// File: rtl/calc_sequencer.sv
// calc_sequencer: hands one command at a time to an external ALU, waits for it to
// settle, then holds the captured result until downstream takes it.
// Optional build macro DZ_COUNT_EN adds dz_count, a saturating divide-by-zero capture count.
module calc_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  output logic [1:0] alu_s,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  input  logic [4:0] alu_answer,
  input  logic       alu_dz,
  input  logic       alu_z,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [4:0] res_value,
  output logic       res_dz,
  output logic       res_z
`ifdef DZ_COUNT_EN
  ,output logic [3:0] dz_count
`endif
);

  // state  | meaning
  // IDLE   | ready for a command, ALU operands hold the last accepted command
  // SETTLE | operands driven to ALU, counting down the settle time
  // HOLD   | result captured and offered downstream until res_ready
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic       r_live;
  logic [1:0] r_alu_s;
  logic [2:0] r_alu_a;
  logic [2:0] r_alu_b;
  logic       r_res_valid;
  logic [4:0] r_res_value;
  logic       r_res_dz;
  logic       r_res_z;
  logic       w_accept;
  logic       w_capture;
  logic       w_release;

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_live) begin
          w_accept     = 1'b1;
          w_next_state = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_capture    = 1'b1;
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          w_release    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // r_live keeps cmd_ready low between reset release and the first clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_live  <= 1'b0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_live  <= 1'b1;
      if (w_accept) begin
        r_cnt <= LP_SETTLE;
      end else if (r_state == ST_SETTLE && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_s <= 2'd0;
      r_alu_a <= 3'd0;
      r_alu_b <= 3'd0;
    end else if (w_accept) begin
      r_alu_s <= cmd_op;
      r_alu_a <= cmd_a;
      r_alu_b <= cmd_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_value <= 5'd0;
      r_res_dz    <= 1'b0;
      r_res_z     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_value <= alu_answer;
        r_res_dz    <= alu_dz;
        r_res_z     <= alu_z;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef DZ_COUNT_EN
  logic [3:0] r_dz_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dz_count <= 4'd0;
    end else if (w_capture && alu_dz && r_dz_count != 4'd15) begin
      r_dz_count <= r_dz_count + 4'd1;
    end
  end

  assign dz_count = r_dz_count;
`endif

  assign cmd_ready = r_live && (r_state == ST_IDLE);
  assign alu_s     = r_alu_s;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign res_valid = r_res_valid;
  assign res_value = r_res_value;
  assign res_dz    = r_res_dz;
  assign res_z     = r_res_z;

endmodule
